// File: rtl/mul_pkg.sv
// Shared types and constants for the MULT/MULTU sequencer and its HI/LO register pair.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    localparam int unsigned MUL_LAT_DEFAULT = 1;
    localparam int unsigned HILO_W          = 32;
    // Holds MUL_LAT-1 for the supported latency range of 1..4.
    localparam int unsigned CNT_W           = 2;

endpackage

// File: rtl/mul_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO pair: product commit has priority over MTHI/MTLO, reset clears both.
module hilo_regs
    import mul_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                prod_we_i,
    input  logic [2*HILO_W-1:0] prod_i,
    input  logic                mt_en_i,
    input  logic                hi_we_i,
    input  logic                lo_we_i,
    input  logic [HILO_W-1:0]   wdata_i,
    output logic [HILO_W-1:0]   hi_o,
    output logic [HILO_W-1:0]   lo_o
);

    logic [HILO_W-1:0] hi_q, hi_d;
    logic [HILO_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (prod_we_i) begin
            hi_d = prod_i[2*HILO_W-1:HILO_W];
            lo_d = prod_i[HILO_W-1:0];
        end else if (mt_en_i) begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequences a MULT/MULTU through the tree multiplier, stalls EX, and commits the product to HI/LO.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    input  logic                req_signed,
    input  logic [HILO_W-1:0]   req_op1,
    input  logic [HILO_W-1:0]   req_op2,
    input  logic                hi_we,
    input  logic                lo_we,
    input  logic [HILO_W-1:0]   hilo_wdata,
    output logic                mul_start,
    output logic                mul_sign,
    output logic [HILO_W-1:0]   mul_op1,
    output logic [HILO_W-1:0]   mul_op2,
    input  logic [2*HILO_W-1:0] mul_result,
    output logic                stallreq,
    output logic                done,
    output logic [HILO_W-1:0]   hi,
    output logic [HILO_W-1:0]   lo
);

    mul_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start_q;
    logic              sign_q;
    logic [HILO_W-1:0] op1_q;
    logic [HILO_W-1:0] op2_q;
    logic              done_q;

    logic commit;
    logic mt_en;

    // Flush beats the final-cycle commit, so a flushed product never reaches HI/LO.
    assign commit = (state_q == ST_WAIT) && (cnt_q == '0) && !flush;
    assign mt_en  = (state_q == ST_IDLE) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            sign_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        sign_q  <= req_signed;
                        op1_q   <= req_op1;
                        op2_q   <= req_op2;
                        start_q <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= CNT_W'(MUL_LAT - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // req_valid here is the instruction being released; do not re-accept it.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stallreq = !rst && !flush &&
                      (((state_q == ST_IDLE) && req_valid) ||
                       (state_q == ST_LOAD) || (state_q == ST_WAIT));

    hilo_regs u_hilo (
        .clk_i     (clk),
        .rst_i     (rst),
        .prod_we_i (commit),
        .prod_i    (mul_result),
        .mt_en_i   (mt_en),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .wdata_i   (hilo_wdata),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    assign mul_start = start_q;
    assign mul_sign  = sign_q;
    assign mul_op1   = op1_q;
    assign mul_op2   = op2_q;
    assign done      = done_q;

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencer between the EX-stage decode and the 32×32 tree multiplier. It accepts MULT/MULTU requests from EX, drives the multiplier's start/sign/operand inputs for the required number of cycles, and stalls the pipeline until the product is ready. It then commits the 64-bit product into the architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO to MFHI/MFLO.

## Interface
Parameters:
- `MUL_LAT`, default 1: multiplier cycles from the first registered-operand edge to a valid `mul_result`; range 1–4.

Ports:
- `clk`  in  1  — single clock, all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `flush`  in  1  — pipeline flush (exception/eret); aborts any operation.
- `req_valid`  in  1  — EX holds a MULT/MULTU.
- `req_signed`  in  1  — 1 = MULT, 0 = MULTU.
- `req_op1`, `req_op2`  in  32  — rs/rt values.
- `hi_we`, `lo_we`  in  1  — MTHI/MTLO write enables.
- `hilo_wdata`  in  32  — MTHI/MTLO data.
- `mul_start`  out  1  — multiplier start; held high for the whole operation.
- `mul_sign`  out  1  — latched `req_signed`.
- `mul_op1`, `mul_op2`  out  32  — latched operands.
- `mul_result`  in  64  — multiplier product.
- `stallreq`  out  1  — stall request to pipeline control.
- `done`  out  1  — one-cycle pulse when HI/LO have been updated.
- `hi`, `lo`  out  32  — architectural HI/LO.

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE. The encoding is defined in the package.
- IDLE:
  - `req_valid & ~flush` latches `req_signed`/ops into `mul_sign`/`mul_op*` and moves to LOAD.
  - `stallreq = req_valid & ~flush` (combinational).
  - `hi_we`/`lo_we` write `hilo_wdata` into HI/LO at the clock edge, only in IDLE and only when no flush. If both are set, both registers take the same data.
- LOAD: `mul_start=1`, `stallreq=1`. The multiplier registers its partial products at the end of this cycle. Load the counter with `MUL_LAT-1`, then go to WAIT.
- WAIT:
  - `mul_start=1`, `stallreq=1`; the counter decrements each cycle.
  - When the counter reaches 0: HI ← `mul_result[63:32]`, LO ← `mul_result[31:0]` at that edge, then go to DONE.
- DONE:
  - `mul_start=0`, `stallreq=0`, `done=1`. The EX instruction advances during this cycle.
  - `req_valid` here belongs to the released instruction and is never re-accepted.
  - Next state is IDLE.
- `mul_op*`/`mul_sign` keep their values outside IDLE-accept and are don't-care when `mul_start=0`.
- HI/LO writes from MT* are ignored in LOAD, WAIT and DONE; the pipeline is stalled, so none are legitimate there.

## Timing
- Reset value of every output and register: state = IDLE; `hi`, `lo`, `mul_op1`, `mul_op2` = 0; `mul_sign`, `mul_start`, `done` = 0.
- `stallreq` is 0 during the reset cycle regardless of `req_valid`.
- Accept at cycle 0 (IDLE). Then:
  - LOAD at cycle 1.
  - WAIT at cycles 2 … 1+`MUL_LAT`.
  - HI/LO are new from cycle 2+`MUL_LAT`, which is the DONE cycle.
- `stallreq` is high for `MUL_LAT`+2 consecutive cycles, then low in DONE.
- Back-to-back MULTs: the second one is accepted in the first IDLE after DONE, so the minimum spacing is `MUL_LAT`+3 cycles.
- Flush in any state:
  - Next state is IDLE.
  - `mul_start` drops at the next edge.
  - HI/LO are unchanged, including when flush coincides with the final WAIT cycle (flush wins over commit).
  - No `done` pulse.
  - `stallreq` = 0 in the flush cycle.
- `rst` mid-operation has the same effect as flush, and additionally clears HI/LO.

## Structure
- Package `mul_pkg`:
  - FSM state typedef (IDLE/LOAD/WAIT/DONE).
  - `MUL_LAT_DEFAULT` = 1.
  - `HILO_W` = 32.
- One sub-module, `hilo_regs`: the HI/LO register pair. It takes a 64-bit product write port and independent 32-bit MTHI/MTLO ports, applies the priority rule (product commit in WAIT, MT* only in IDLE), and performs the synchronous clear.
- The FSM and counter stay in the top module.

## Test plan
- MULTU with `0xFFFFFFFF × 0xFFFFFFFF`, `MUL_LAT`=1 → `stallreq` high for 3 cycles; in DONE, `hi=0xFFFFFFFE`, `lo=0x00000001`, `done`=1 for exactly one cycle.
- MULT with `0xFFFFFFFD (−3) × 0x00000007` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`; `mul_sign`=1 throughout LOAD/WAIT.
- MTHI `0x12345678`, then MTLO `0x9ABCDEF0` in IDLE → `hi`/`lo` take those values one edge later, with no stall.
- MULT accepted, then flush asserted in the WAIT cycle → HI/LO keep their prior values, no `done`, state IDLE next cycle, `mul_start`=0.
- Two back-to-back MULTUs (`3×5`, then `7×11`) with `req_valid` held → after the first DONE, `lo=15`; after the second, `lo=77` with `hi=0`. Verify the second is accepted only after DONE.
- `rst` pulsed during LOAD with `hi`/`lo` nonzero → all outputs return to reset values the next cycle; `MUL_LAT`=3 rerun gives `stallreq` high for 5 cycles.
